// File: rtl/comp_pkg.sv
// Shared encodings and elaboration limits for the serial magnitude comparator.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/comp_bit_eq.sv
// 1-bit equality cell: o_eq = ~(i_x ^ i_y). Purely combinational.
module comp_bit_eq (
  input  logic i_x,
  input  logic i_y,
  output logic o_eq
);

  assign o_eq = ~(i_x ^ i_y);

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first unsigned compare. Latency is the MSB-relative position of the first differing bit (1..WIDTH).
// start is only sampled in IDLE. While busy, it is dropped without queuing.
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_bad
    $error("serial_mag_comp: WIDTH out of legal range");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_eq;
  logic               r_gt;
  logic               r_lt;
  logic               w_bit_eq;

  comp_bit_eq u_bit_eq (
    .i_x  (r_sa[WIDTH-1]),
    .i_y  (r_sb[WIDTH-1]),
    .o_eq (w_bit_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa    <= i0;
            r_sb    <= i1;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          // First differing MSB decides: A owns the 1 -> A is greater.
          if (!w_bit_eq) begin
            r_gt    <= r_sa[WIDTH-1];
            r_lt    <= ~r_sa[WIDTH-1];
            r_eq    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == '0) begin
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
            r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule
